// File: rtl/weight_fifo_bank_pkg.sv
// Shared constants and loader state encoding for the weight FIFO bank.
package weight_fifo_bank_pkg;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned N      = 16;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_FLUSH = 2'd2
    } load_state_e;

endpackage

// File: rtl/weight_fifo_bank_if.sv
// Weight-memory read port: the bank issues row reads, memory returns a full row a cycle later.
interface weight_fifo_bank_if
    import weight_fifo_bank_pkg::*;
#(
    parameter int unsigned COLS   = N,
    parameter int unsigned ELEM_W = WIDTH,
    parameter int unsigned AW     = ADDR_W
) ();

    logic                     mem_en;
    logic [AW-1:0]            mem_addr;
    logic [COLS*ELEM_W-1:0]   mem_rdata;

    modport master (
        output mem_en,
        output mem_addr,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_addr,
        output mem_rdata
    );

endinterface

// File: rtl/weight_column_fifo.sv
// One column of the bank: DEPTH-entry shift FIFO, head at index 0, registered head output.
module weight_column_fifo
    import weight_fifo_bank_pkg::*;
#(
    parameter int unsigned DEPTH = N,
    parameter int unsigned W     = WIDTH,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    logic [W-1:0] store [DEPTH];

    // Push and pop never coincide: pushes happen only while loading, pops only when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                store[i] <= '0;
            end
            count <= '0;
            head  <= '0;
        end else begin
            if (pop) begin
                if (count != '0) begin
                    head <= store[0];
                    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                        store[i] <= store[i+1];
                    end
                    store[DEPTH-1] <= '0;
                end else begin
                    head <= '0;
                end
            end
            if (push) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (count == CW'(i)) begin
                        store[i] <= push_data;
                    end
                end
            end
            if (clear) begin
                count <= '0;
            end else if (push) begin
                count <= count + CW'(1);
            end else if (pop && (count != '0)) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/weight_fifo_bank.sv
// Loads N weight rows into N column FIFOs, then drains each column under its own enable.
module weight_fifo_bank
    import weight_fifo_bank_pkg::*;
#(
    parameter int unsigned WIDTH_P  = WIDTH,
    parameter int unsigned N_P      = N,
    parameter int unsigned ADDR_W_P = ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_start,
    input  logic [ADDR_W_P-1:0]     load_base,
    weight_fifo_bank_if.master      mem,
    output logic                    load_busy,
    output logic                    load_done,
    input  logic [N_P-1:0]          fifo_en,
    output logic [N_P*WIDTH_P-1:0]  weight_out,
    output logic [N_P-1:0]          col_empty,
    output logic                    full
);

    localparam int unsigned CW = $clog2(N_P + 1);

    load_state_e     state;
    logic [CW-1:0]   issue_cnt;
    logic            rd_valid;
    logic            clear_c;
    logic [N_P-1:0]  pop_c;
    logic [N_P-1:0]  col_full_c;
    logic [CW-1:0]   count [N_P];

    assign clear_c = (state == ST_IDLE) && load_start;
    assign pop_c   = (state == ST_IDLE) ? fifo_en : '0;

    // Loader: issue_cnt holds the number of reads already issued, including the current one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            issue_cnt    <= '0;
            mem.mem_en   <= 1'b0;
            mem.mem_addr <= '0;
            load_busy    <= 1'b0;
            load_done    <= 1'b0;
            rd_valid     <= 1'b0;
        end else begin
            rd_valid  <= mem.mem_en;
            load_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        state        <= ST_ISSUE;
                        mem.mem_en   <= 1'b1;
                        mem.mem_addr <= load_base;
                        issue_cnt    <= CW'(1);
                        load_busy    <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (issue_cnt == CW'(N_P)) begin
                        state      <= ST_FLUSH;
                        mem.mem_en <= 1'b0;
                    end else begin
                        mem.mem_addr <= mem.mem_addr + ADDR_W_P'(1);
                        issue_cnt    <= issue_cnt + CW'(1);
                    end
                end
                ST_FLUSH: begin
                    state     <= ST_IDLE;
                    load_busy <= 1'b0;
                    load_done <= 1'b1;
                end
                default: begin
                    state      <= ST_IDLE;
                    mem.mem_en <= 1'b0;
                    load_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < int'(N_P); c++) begin : g_col
        weight_column_fifo #(
            .DEPTH (N_P),
            .W     (WIDTH_P)
        ) u_col (
            .clk       (clk),
            .reset     (reset),
            .clear     (clear_c),
            .push      (rd_valid),
            .push_data (mem.mem_rdata[c*WIDTH_P +: WIDTH_P]),
            .pop       (pop_c[c]),
            .head      (weight_out[c*WIDTH_P +: WIDTH_P]),
            .count     (count[c])
        );

        assign col_empty[c]  = (count[c] == '0);
        assign col_full_c[c] = (count[c] == CW'(N_P));
    end

    assign full = &col_full_c;

endmodule

// File: tb/tb_weight_fifo_bank.sv
// Scoreboard bench for weight_fifo_bank: queue-based column model, randomized loads and drain masks.
module tb_weight_fifo_bank;
    import weight_fifo_bank_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  load_start;
    logic [ADDR_W-1:0]     load_base;
    logic                  load_busy;
    logic                  load_done;
    logic [N-1:0]          fifo_en;
    logic [N*WIDTH-1:0]    weight_out;
    logic [N-1:0]          col_empty;
    logic                  full;

    weight_fifo_bank_if mem_if ();

    weight_fifo_bank dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_base  (load_base),
        .mem        (mem_if),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .fifo_en    (fifo_en),
        .weight_out (weight_out),
        .col_empty  (col_empty),
        .full       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight memory: registered read, row valid the cycle after mem_en.
    logic [N*WIDTH-1:0] mem_rows [256];
    always @(posedge clk) begin
        if (mem_if.mem_en === 1'b1) mem_if.mem_rdata <= mem_rows[mem_if.mem_addr];
    end

    // Reference model: one queue of weights per column plus the last emitted value.
    logic [WIDTH-1:0]   colq [N][$];
    logic [N*WIDTH-1:0] wo_m;

    typedef struct {
        int                 cyc;
        logic [N*WIDTH-1:0] wo;
        logic [N-1:0]       emp;
        logic               full;
        logic               busy;
        bit                 chk;
    } exp_t;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
    } addr_t;

    exp_t  exp_q [$];
    addr_t addr_q [$];
    int    done_q [$];
    int    tests = 0;
    int    fails = 0;

    function automatic logic [N-1:0] model_empty();
        logic [N-1:0] r;
        for (int c = 0; c < int'(N); c++) r[c] = (colq[c].size() == 0);
        return r;
    endfunction

    function automatic logic model_full();
        logic r = 1'b1;
        for (int c = 0; c < int'(N); c++) if (colq[c].size() != int'(N)) r = 1'b0;
        return r;
    endfunction

    task automatic push_exp(input logic busy, input bit chk);
        exp_t e;
        e.cyc  = cyc + 1;
        e.wo   = wo_m;
        e.emp  = model_empty();
        e.full = model_full();
        e.busy = busy;
        e.chk  = chk;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input logic [N-1:0] en);
        fifo_en    = en;
        load_start = 1'b0;
        for (int c = 0; c < int'(N); c++) begin
            if (en[c]) begin
                if (colq[c].size() > 0) wo_m[c*WIDTH +: WIDTH] = colq[c].pop_front();
                else                    wo_m[c*WIDTH +: WIDTH] = '0;
            end
        end
        push_exp(1'b0, 1'b1);
        step();
    endtask

    // abort_at = 0: full load; otherwise reset is asserted during ISSUE cycle abort_at.
    task automatic start_load(input logic [ADDR_W-1:0] base, input int abort_at);
        int t;
        logic [N*WIDTH-1:0] row;
        t          = cyc;
        load_start = 1'b1;
        load_base  = base;
        fifo_en    = '0;
        for (int c = 0; c < int'(N); c++) colq[c].delete();
        for (int r = 0; r < int'(N); r++) begin
            row = mem_rows[ADDR_W'(base + r)];
            for (int c = 0; c < int'(N); c++) colq[c].push_back(row[c*WIDTH +: WIDTH]);
        end
        for (int k = 0; k < int'(N); k++) begin
            if (abort_at == 0 || k < abort_at) addr_q.push_back('{t + 1 + k, ADDR_W'(base + k)});
        end
        if (abort_at == 0) done_q.push_back(t + int'(N) + 2);
        push_exp(1'b1, 1'b0);
        step();
        for (int j = 1; j <= int'(N) + 1; j++) begin
            if (abort_at != 0 && j == abort_at) begin
                reset      = 1'b1;
                load_start = 1'b0;
                fifo_en    = N'($urandom);
                for (int c = 0; c < int'(N); c++) colq[c].delete();
                wo_m = '0;
                push_exp(1'b0, 1'b1);
                step();
                reset = 1'b0;
                return;
            end
            fifo_en    = N'($urandom);
            load_start = 1'($urandom);
            load_base  = ADDR_W'($urandom);
            push_exp(1'(j < int'(N) + 1), j == int'(N) + 1);
            step();
        end
        load_start = 1'b0;
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    exp_t  mon_e;
    addr_t mon_a;
    int    mon_d;
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mon_e = exp_q.pop_front();
            tests++;
            if (weight_out !== mon_e.wo) begin
                fails++;
                $display("FAIL weight_out cyc=%0d got=%h exp=%h", cyc, weight_out, mon_e.wo);
            end
            tests++;
            if (load_busy !== mon_e.busy) begin
                fails++;
                $display("FAIL load_busy cyc=%0d got=%b exp=%b", cyc, load_busy, mon_e.busy);
            end
            if (mon_e.chk) begin
                tests++;
                if (col_empty !== mon_e.emp) begin
                    fails++;
                    $display("FAIL col_empty cyc=%0d got=%h exp=%h", cyc, col_empty, mon_e.emp);
                end
                tests++;
                if (full !== mon_e.full) begin
                    fails++;
                    $display("FAIL full cyc=%0d got=%b exp=%b", cyc, full, mon_e.full);
                end
            end
        end
        if (mem_if.mem_en === 1'b1) begin
            tests++;
            if (addr_q.size() == 0) begin
                fails++;
                $display("FAIL mem_en_unexpected cyc=%0d got=1 exp=0", cyc);
            end else begin
                mon_a = addr_q.pop_front();
                if (mon_a.cyc != cyc || mem_if.mem_addr !== mon_a.addr) begin
                    fails++;
                    $display("FAIL mem_addr cyc=%0d got=%h exp=%h at cyc %0d",
                             cyc, mem_if.mem_addr, mon_a.addr, mon_a.cyc);
                end
            end
        end else if (addr_q.size() > 0 && addr_q[0].cyc == cyc) begin
            tests++;
            fails++;
            mon_a = addr_q.pop_front();
            $display("FAIL mem_en_missing cyc=%0d got=%b exp=1", cyc, mem_if.mem_en);
        end
        if (load_done === 1'b1) begin
            tests++;
            if (done_q.size() == 0) begin
                fails++;
                $display("FAIL load_done_unexpected cyc=%0d got=1 exp=0", cyc);
            end else begin
                mon_d = done_q.pop_front();
                if (mon_d != cyc || full !== 1'b1 || col_empty !== '0) begin
                    fails++;
                    $display("FAIL load_done cyc=%0d got full=%b empty=%h exp cyc=%0d full=1 empty=0",
                             cyc, full, col_empty, mon_d);
                end
            end
        end else if (done_q.size() > 0 && done_q[0] == cyc) begin
            tests++;
            fails++;
            mon_d = done_q.pop_front();
            $display("FAIL load_done_missing cyc=%0d got=%b exp=1", cyc, load_done);
        end
    end

    logic [N-1:0] mask;

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        load_base  = '0;
        fifo_en    = '0;
        wo_m       = '0;
        for (int a = 0; a < 256; a++)
            for (int c = 0; c < int'(N); c++) mem_rows[a][c*WIDTH +: WIDTH] = WIDTH'(a * 16 + c);

        repeat (2) step();
        push_exp(1'b0, 1'b1);
        step();
        reset = 1'b0;
        drain('0);
        drain('0);

        // Row r element c = 16r+c; full-width drain, then one extra enable cycle.
        start_load(8'h10, 0);
        repeat (int'(N) + 1) drain('1);
        drain('0);

        // Staircase mask: bit c active from step c to step c+N-1.
        start_load(8'h10, 0);
        for (int s = 0; s < 2 * int'(N); s++) begin
            for (int c = 0; c < int'(N); c++) mask[c] = (c <= s) && (s < c + int'(N));
            drain(mask);
        end

        // Address wrap with random weights.
        for (int a = 0; a < 256; a++)
            for (int c = 0; c < int'(N); c++) mem_rows[a][c*WIDTH +: WIDTH] = WIDTH'($urandom);
        start_load(8'hF8, 0);
        repeat (int'(N) + 1) drain('1);

        // Random bases and masks, odd iterations reload back-to-back in the done cycle.
        for (int it = 0; it < 4; it++) begin
            for (int a = 0; a < 256; a++)
                for (int c = 0; c < int'(N); c++) mem_rows[a][c*WIDTH +: WIDTH] = WIDTH'($urandom);
            start_load(ADDR_W'($urandom), 0);
            if (it % 2 == 1) start_load(ADDR_W'($urandom), 0);
            for (int k = 0; k < 24; k++) begin
                case ($urandom_range(0, 3))
                    0:       drain('0);
                    1:       drain('1);
                    default: drain(N'($urandom));
                endcase
            end
        end

        // Reset during ISSUE cycle 7: in-flight row dropped, no done pulse, columns stay empty.
        start_load(8'h40, 7);
        drain('1);
        drain('0);
        drain(N'($urandom));
        drain('0);
        step();
        step();

        tests++;
        if (exp_q.size() != 0 || addr_q.size() != 0 || done_q.size() != 0) begin
            fails++;
            $display("FAIL leftover_expectations got exp=%0d addr=%0d done=%0d exp=0",
                     exp_q.size(), addr_q.size(), done_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/weight_fifo_bank.md
# weight_fifo_bank

Bank of N per-column weight FIFOs sitting between weight memory and the matrix-multiply unit (MMU). A loader FSM reads N consecutive weight-memory rows and pushes element c of each row into column FIFO c; afterwards each column is drained independently under the per-column enable mask produced by the staircase FIFO controller, delivering skewed weights into the MMU columns.

## Interface
- WIDTH, 8, bits per weight element
- N, 16, number of columns = depth of each column FIFO
- ADDR_W, 8, weight-memory address width

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- load_start  in  1  start load of N rows; sampled only in IDLE
- load_base  in  ADDR_W  first row address, captured with load_start
- mem_en  out  1  weight-memory read enable
- mem_addr  out  ADDR_W  weight-memory read address
- mem_rdata  in  N*WIDTH  row data, valid the cycle after mem_en; element c at bits [c*WIDTH +: WIDTH]
- load_busy  out  1  load in progress
- load_done  out  1  one-cycle pulse, all columns full
- fifo_en  in  N  per-column drain enable
- weight_out  out  N*WIDTH  registered per-column head data to MMU
- col_empty  out  N  column c holds 0 entries
- full  out  1  every column holds N entries

## Operation
- FSM states: IDLE, ISSUE, FLUSH.
- IDLE: on load_start, capture load_base, clear all column counts (old contents discarded), go ISSUE, load_busy=1.
- ISSUE: N cycles; cycle k (0..N-1) drives mem_en=1, mem_addr=load_base+k, mod 2^ADDR_W (wraps). After k=N-1 go FLUSH.
- FLUSH: one cycle; final row pushed at its end; then IDLE with load_done=1 for one cycle.
- Push: each cycle after a mem_en cycle, element c of mem_rdata enters tail of column c; count[c]+1. First row read = first row out (FIFO order).
- Drain (IDLE only): fifo_en[c]=1 and count[c]>0 -> weight_out[c] <= head, shift toward head, count[c]-1. fifo_en[c]=1 and count[c]=0 -> weight_out[c] <= 0. fifo_en[c]=0 -> weight_out[c] holds.
- fifo_en ignored while load_busy=1; load_start ignored while load_busy=1.
- Counts range 0..N; push never exceeds N (counts cleared at load start); no overflow path.
- col_empty[c] = (count[c]==0); full = all counts == N; both combinational from count registers.
- Reset (any time, including mid-load): state IDLE, counts 0, all storage 0, weight_out 0, mem_en 0, mem_addr 0, load_busy 0, load_done 0, col_empty all 1, full 0. A read issued before reset whose data returns afterwards is not pushed.

## Timing
- load_start high at edge E0: ISSUE during cycles 1..N (mem_en=1), FLUSH cycle N+1, pushes at edges 2..N+1, load_done=1 and full=1 during cycle N+2, load_busy=1 during cycles 1..N+1.
- Load-to-full latency N+2 cycles; back-to-back load_start accepted in the load_done cycle.
- Drain latency: fifo_en[c] high in cycle t -> new weight_out[c] visible in cycle t+1.
- A column given N consecutive enable cycles emits rows 0..N-1 in order; staircase mask (bit c rising at cycle c, falling at cycle c+N) yields column c emitting row r in cycle c+r+1.

## Structure
- Shared package: WIDTH, N, ADDR_W defaults, FSM state encoding (IDLE/ISSUE/FLUSH), count width $clog2(N+1).
- Sub-module weight_column_fifo: one N-deep WIDTH-bit shift FIFO with push, pop, count, registered head output; instantiated N times via generate.
- Top holds loader FSM, address counter, read-valid delay flop, full/empty reduction.

## Test plan
- Reset then idle -> weight_out 0, col_empty 16'hFFFF, full 0, mem_en 0.
- load_base=8'h10, memory row r element c = r*16+c -> mem_addr 10..1F cycles 1..16, load_done pulse cycle 18, full=1.
- After load, fifo_en=16'hFFFF for 16 cycles -> column c outputs c, 16+c, ..., 240+c; col_empty all 1 after; 17th enable cycle -> weight_out all 0.
- After load, staircase mask (1,3,7,...,FFFF,FFFE,...,8000,0) -> column 5 emits row r in cycle 6+r; all columns empty at end.
- load_base=8'hF8 -> mem_addr F8..FF,00..07 (wrap); data order preserved.
- reset asserted in ISSUE cycle 7 -> next cycle IDLE, counts 0, no push of in-flight row, load_done never pulses; fifo_en during load has no effect.
